sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port single-word arbiter in front of sram_ctrl: IDLE picks a winner, ACCESS drives the SRAM, DONE acks.
// Optional build macro SRAM_ARB_RR_EN replaces p0 priority + starvation forcing with strict round robin.
module sram_arbiter #(
    parameter int unsigned READ_CYCLES  = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [3:0]  p0_be_i,
    input  logic [31:0] p0_wdata_i,
    output logic [31:0] p0_rdata_o,
    output logic        p0_ack_o,
    output logic        p0_busy_o,
    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [3:0]  p1_be_i,
    input  logic [31:0] p1_wdata_i,
    output logic [31:0] p1_rdata_o,
    output logic        p1_ack_o,
    output logic        p1_busy_o,
    output logic        enable_o,
    output logic        readEnable_o,
    output logic [31:0] addr_o,
    output logic [3:0]  byteSelect_o,
    output logic [31:0] dataSave_o,
    input  logic [31:0] dataLoad_i,
    input  logic        busy_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    localparam logic [2:0] READ_LAST = 3'(READ_CYCLES - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        enable_q, enable_d;
    logic        ren_q, ren_d;
    logic [31:0] addr_out_q, addr_out_d;
    logic [3:0]  be_out_q, be_out_d;
    logic [31:0] dsave_q, dsave_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;

    logic        any_req;
    logic        grant1;
    logic        access_d;

    assign any_req = p0_req_i | p1_req_i;

`ifdef SRAM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant1       = p1_req_i;
        last_grant_d = last_grant_q;
        if (p0_req_i && p1_req_i) begin
            grant1 = ~last_grant_q;
        end
        if (state_q == S_IDLE && any_req) begin
            last_grant_d = grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [7:0] starve_q, starve_d;
    logic       p1_in_flight;

    assign p1_in_flight = (state_q != S_IDLE) && owner_q;

    always_comb begin
        grant1   = p1_req_i && (!p0_req_i || starve_q == STARVE_MAX);
        starve_d = starve_q;
        if (state_q == S_IDLE && any_req && grant1) begin
            starve_d = '0;
        end else if (p1_req_i && !p1_in_flight && starve_q < STARVE_MAX) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = grant1;
                    we_d    = grant1 ? p1_we_i    : p0_we_i;
                    addr_d  = grant1 ? p1_addr_i  : p0_addr_i;
                    be_d    = grant1 ? p1_be_i    : p0_be_i;
                    wdata_d = grant1 ? p1_wdata_i : p0_wdata_i;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    if (cnt_q == READ_LAST) begin
                        if (owner_q) begin
                            rdata1_d = dataLoad_i;
                        end else begin
                            rdata0_d = dataLoad_i;
                        end
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (cnt_q != 3'd0 && !busy_i) begin
                    // busy_i is only trusted after sram_ctrl has seen one enabled cycle.
                    state_d = S_DONE;
                end else begin
                    cnt_d = 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM-side outputs are registered from the next state so they are exactly 0 outside ACCESS.
    always_comb begin
        access_d   = (state_d == S_ACCESS);
        enable_d   = access_d;
        ren_d      = access_d & ~we_d;
        addr_out_d = access_d ? addr_d  : '0;
        be_out_d   = access_d ? be_d    : '0;
        dsave_d    = access_d ? wdata_d : '0;
        ack0_d     = (state_d == S_DONE) & ~owner_d;
        ack1_d     = (state_d == S_DONE) &  owner_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            enable_q   <= 1'b0;
            ren_q      <= 1'b0;
            addr_out_q <= '0;
            be_out_q   <= '0;
            dsave_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            enable_q   <= enable_d;
            ren_q      <= ren_d;
            addr_out_q <= addr_out_d;
            be_out_q   <= be_out_d;
            dsave_q    <= dsave_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end
    end

    assign enable_o     = enable_q;
    assign readEnable_o = ren_q;
    assign addr_o       = addr_out_q;
    assign byteSelect_o = be_out_q;
    assign dataSave_o   = dsave_q;
    assign p0_rdata_o   = rdata0_q;
    assign p1_rdata_o   = rdata1_q;
    assign p0_ack_o     = ack0_q;
    assign p1_ack_o     = ack1_q;
    assign p0_busy_o    = p0_req_i & ~ack0_q;
    assign p1_busy_o    = p1_req_i & ~ack1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a vector table of single transactions plus hand-written
// sequences for reset, dropped requests, mid-access reset and sustained two-port contention.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        p0_ack_o, p0_busy_o, p1_ack_o, p1_busy_o;
    logic        enable_o, readEnable_o;
    logic [31:0] addr_o, dataSave_o, dataLoad_i;
    logic [3:0]  byteSelect_o;
    logic        busy_i;

    always #5 clk = ~clk;

    sram_arbiter #(.READ_CYCLES(1), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_be_i(p0_be_i),
        .p0_wdata_i(p0_wdata_i), .p0_rdata_o(p0_rdata_o), .p0_ack_o(p0_ack_o), .p0_busy_o(p0_busy_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_be_i(p1_be_i),
        .p1_wdata_i(p1_wdata_i), .p1_rdata_o(p1_rdata_o), .p1_ack_o(p1_ack_o), .p1_busy_o(p1_busy_o),
        .enable_o(enable_o), .readEnable_o(readEnable_o), .addr_o(addr_o),
        .byteSelect_o(byteSelect_o), .dataSave_o(dataSave_o),
        .dataLoad_i(dataLoad_i), .busy_i(busy_i)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] dload;
        int          busy_cycles;
        int          exp_en_cycles;
        logic [31:0] exp_rdata0;
        logic [31:0] exp_rdata1;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   n_en;
        logic early_ack;
        if (v.port) begin
            p1_req_i = 1'b1; p1_we_i = v.we; p1_addr_i = v.addr; p1_be_i = v.be; p1_wdata_i = v.wdata;
        end else begin
            p0_req_i = 1'b1; p0_we_i = v.we; p0_addr_i = v.addr; p0_be_i = v.be; p0_wdata_i = v.wdata;
        end
        dataLoad_i = v.dload;
        busy_i     = 1'b0;
        for (int i = 0; i < 8 && !enable_o; i++) tick();
        check({tag, " enable"}, enable_o, 1);
        check({tag, " addr"}, addr_o, v.addr);
        check({tag, " byteSelect"}, byteSelect_o, v.be);
        check({tag, " readEnable"}, readEnable_o, !v.we);
        if (v.we) check({tag, " dataSave"}, dataSave_o, v.wdata);
        n_en      = 0;
        early_ack = 1'b0;
        while (enable_o && n_en < 16) begin
            n_en++;
            early_ack = early_ack | p0_ack_o | p1_ack_o;
            busy_i = (n_en <= v.busy_cycles);
            tick();
        end
        busy_i = 1'b0;
        check({tag, " ack during access"}, early_ack, 0);
        check({tag, " enable cycles"}, n_en, v.exp_en_cycles);
        check({tag, " ack"}, v.port ? p1_ack_o : p0_ack_o, 1);
        check({tag, " other ack"}, v.port ? p0_ack_o : p1_ack_o, 0);
        check({tag, " busy at ack"}, v.port ? p1_busy_o : p0_busy_o, 0);
        check({tag, " p0 rdata"}, p0_rdata_o, v.exp_rdata0);
        check({tag, " p1 rdata"}, p1_rdata_o, v.exp_rdata1);
        p0_req_i = 1'b0;
        p1_req_i = 1'b0;
        tick();
        check({tag, " ack single pulse"}, p0_ack_o | p1_ack_o, 0);
    endtask

    vec_t vecs[8];
    vec_t post_rst;
    logic exp_seq[16];
    int   acks, p1_acks, exp_p1_acks;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 4'hF,    32'h0,         32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 4'b0011, 32'hCAFE_F00D, 32'h1111_1111, 3, 4, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 4'hF,    32'h0,         32'h1234_5678, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0014, 4'b1000, 32'hA5A5_A5A5, 32'h2222_2222, 0, 2, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0018, 4'hF,    32'h0102_0304, 32'h3333_3333, 1, 2, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 4'hF,    32'h0,         32'h0,         0, 1, 32'h0,         32'h1234_5678};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0000, 4'b0001, 32'h0,         32'hFFFF_FFFF, 0, 1, 32'h0,         32'hFFFF_FFFF};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0020, 4'b0110, 32'h7777_8888, 32'h4444_4444, 2, 3, 32'h0,         32'hFFFF_FFFF};
        post_rst = '{1'b0, 1'b0, 32'h0000_0080, 4'hF,   32'h0,         32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 32'h0};

        rst_n = 1'b0;
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'h40; p0_be_i = 4'hF; p0_wdata_i = 32'h0;
        p1_req_i = 1'b0; p1_we_i = 1'b0; p1_addr_i = 32'h0;  p1_be_i = 4'h0; p1_wdata_i = 32'h0;
        dataLoad_i = 32'h0; busy_i = 1'b0;

        // Reset held with a request pending.
        repeat (3) tick();
        check("rst enable", enable_o, 0);
        check("rst readEnable", readEnable_o, 0);
        check("rst addr", addr_o, 0);
        check("rst byteSelect", byteSelect_o, 0);
        check("rst dataSave", dataSave_o, 0);
        check("rst acks", {p0_ack_o, p1_ack_o}, 0);
        check("rst rdata", p0_rdata_o | p1_rdata_o, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2 && !enable_o; i++) tick();
        check("first grant enable", enable_o, 1);
        check("first grant addr", addr_o, 32'h40);
        for (int i = 0; i < 8 && !p0_ack_o; i++) tick();
        check("first grant ack", p0_ack_o, 1);
        p0_req_i = 1'b0;
        tick();

        busy_i = 1'b1;
        repeat (3) tick();
        check("busy in idle ignored", enable_o, 0);
        busy_i = 1'b0;

        for (int k = 0; k < 8; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

        // Reset pulsed while a write waits on busy.
        p1_req_i = 1'b1; p1_we_i = 1'b1; p1_addr_i = 32'h300; p1_be_i = 4'hF; p1_wdata_i = 32'h55AA_55AA;
        busy_i = 1'b1;
        for (int i = 0; i < 8 && !enable_o; i++) tick();
        check("midrst enable before", enable_o, 1);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst enable async", enable_o, 0);
        check("midrst addr async", addr_o, 0);
        p1_req_i = 1'b0;
        busy_i = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("midrst no ack", {p0_ack_o, p1_ack_o}, 0);
        run_txn(post_rst, "post reset");

        // Request withdrawn before ack: the transaction still completes.
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'h90; p0_be_i = 4'hF;
        dataLoad_i = 32'h600D_CAFE;
        tick();
        p0_req_i = 1'b0;
        for (int i = 0; i < 6 && !p0_ack_o; i++) tick();
        check("dropped req ack", p0_ack_o, 1);
        check("dropped req rdata", p0_rdata_o, 32'h600D_CAFE);
        tick();

        // Both ports requesting continuously from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
`ifdef SRAM_ARB_RR_EN
            exp_seq[i] = (i % 2 == 1);
`else
            exp_seq[i] = (i % 4 == 3);
`endif
        end
`ifdef SRAM_ARB_RR_EN
        exp_p1_acks = 8;
`else
        exp_p1_acks = 4;
`endif
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'h100; p0_be_i = 4'hF;
        p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 32'h104; p1_be_i = 4'hF;
        dataLoad_i = 32'h0;
        acks = 0;
        p1_acks = 0;
        for (int cyc = 0; cyc < 200 && acks < 16; cyc++) begin
            tick();
            if (p0_ack_o || p1_ack_o) begin
                check($sformatf("contention grant %0d p1", acks), p1_ack_o, exp_seq[acks]);
                check($sformatf("contention grant %0d p0", acks), p0_ack_o, !exp_seq[acks]);
                if (p1_ack_o) p1_acks++;
                acks++;
            end
        end
        check("contention ack total", acks, 16);
        check("contention p1 acks", p1_acks, exp_p1_acks);
        p0_req_i = 1'b0;
        p1_req_i = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
